// File: rtl/pool_pkg.sv
// pool_pkg: shared FSM state type and signed max helper for the max-pool sequencer
package pool_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  function automatic logic signed [63:0] max2(input logic signed [63:0] a, input logic signed [63:0] b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/max4_signed.sv
// max4_signed: two-level signed compare tree over the four line-buffer taps
module max4_signed
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] tap0,
  input  logic [DATA_WIDTH-1:0] tap1,
  input  logic [DATA_WIDTH-1:0] tap2,
  input  logic [DATA_WIDTH-1:0] tap3,
  output logic [DATA_WIDTH-1:0] max_o
);
  logic signed [63:0] m01, m23;
  // pairwise maxima, then the final compare; taps are sign-extended into the helper's width
  always_comb begin
    m01 = max2(64'(signed'(tap0)), 64'(signed'(tap1)));
    m23 = max2(64'(signed'(tap2)), 64'(signed'(tap3)));
    max_o = DATA_WIDTH'(max2(m01, m23));
  end
endmodule

// File: rtl/maxpool_ctrl.sv
// maxpool_ctrl: 2x2 stride-2 max-pool sequencer; define MAXPOOL_RELU_EN to clamp negative results to 0
module maxpool_ctrl
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 5,
  parameter int HEIGHT     = 5,
  parameter int CW         = $clog2(WIDTH),
  parameter int RW         = $clog2(HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  lb_shift,
  input  logic [DATA_WIDTH-1:0] tap0,
  input  logic [DATA_WIDTH-1:0] tap1,
  input  logic [DATA_WIDTH-1:0] tap2,
  input  logic [DATA_WIDTH-1:0] tap3,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic [CW-1:0]         col,
  output logic [RW-1:0]         row
);
  state_t                state_q, state_d;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic                  cmp_pend_q, cmp_pend_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [DATA_WIDTH-1:0] mx, mx_r;
  logic                  stall, accept, last_col, last_row, load;

  max4_signed #(.DATA_WIDTH(DATA_WIDTH)) u_max (
    .tap0 (tap0),
    .tap1 (tap1),
    .tap2 (tap2),
    .tap3 (tap3),
    .max_o(mx)
  );

  // handshakes, raster counters, window pending flag, output slot and next state
  always_comb begin
    stall      = m_valid_q & ~m_ready;
    s_ready    = (state_q == RUN) & ~stall & ~(cmp_pend_q & stall);
    accept     = s_valid & s_ready;
    last_col   = col_q == CW'(WIDTH - 1);
    last_row   = row_q == RW'(HEIGHT - 1);
    load       = cmp_pend_q & ~stall;
`ifdef MAXPOOL_RELU_EN
    mx_r       = mx[DATA_WIDTH-1] ? '0 : mx;
`else
    mx_r       = mx;
`endif
    col_d      = (state_q == IDLE && start) ? '0 : accept ? (last_col ? '0 : col_q + 1'b1) : col_q;
    row_d      = (state_q == IDLE && start) ? '0 : (accept && last_col) ? (last_row ? '0 : row_q + 1'b1) : row_q;
    cmp_pend_d = (accept & col_q[0] & row_q[0]) | (cmp_pend_q & ~load);
    m_valid_d  = load | stall;
    m_data_d   = load ? mx_r : m_data_q;
    state_d    = (state_q == IDLE && start) ? RUN :
                 (accept && last_col && last_row) ? DRAIN :
                 (state_q == DRAIN && !cmp_pend_q && !m_valid_q) ? DONE :
                 (state_q == DONE) ? IDLE : state_q;
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      cmp_pend_q <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      cmp_pend_q <= cmp_pend_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
    end
  end

  assign lb_shift = accept;
  assign m_data   = m_data_q;
  assign m_valid  = m_valid_q;
  assign busy     = state_q != IDLE;
  assign done     = state_q == DONE;
  assign col      = col_q;
  assign row      = row_q;
endmodule

// File: tb/tb_maxpool_ctrl.sv
// tb_maxpool_ctrl: directed bench with a behavioural line buffer feeding the taps
module tb_maxpool_ctrl;
  localparam int DW = 32;
  localparam int W  = 5;
  localparam int H  = 5;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, s_valid = 1'b0, m_ready = 1'b1;
  logic s_ready, lb_shift, m_valid, busy, done;
  logic [DW-1:0] tap0, tap1, tap2, tap3;
  logic signed [DW-1:0] m_data;
  logic [2:0] col, row;
  logic signed [DW-1:0] pix = '0;
  logic signed [DW-1:0] sr [0:W+1];
  int tests = 0, fails = 0, cyc = 0, done_cnt = 0, shift_cnt = 0, lat_chk = 0;
  logic signed [DW-1:0] got [$];
  int acc_cyc [$];

  maxpool_ctrl #(.DATA_WIDTH(DW), .WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .lb_shift(lb_shift), .tap0(tap0), .tap1(tap1), .tap2(tap2), .tap3(tap3),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy),
    .done(done), .col(col), .row(row)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (lb_shift) begin
      sr[0] <= pix;
      for (int i = 1; i < W + 2; i++) sr[i] <= sr[i-1];
    end
  end

  assign tap3 = sr[0];
  assign tap2 = sr[1];
  assign tap1 = sr[W];
  assign tap0 = sr[W+1];

  task automatic chk(input string tag, input logic signed [63:0] got_v, input logic signed [63:0] exp_v);
    tests++;
    if (got_v !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (lb_shift) shift_cnt++;
    if (m_valid && m_ready) begin
      got.push_back(m_data);
      if (lat_chk != 0) begin
        if (acc_cyc.size() > 0) chk("latency", cyc, acc_cyc.pop_front() + 2);
        else chk("unexpected_result", 1, 0);
      end
    end
  end

  task automatic send(input int v, input int idx, input bit st);
    int k;
    pix = v;
    s_valid = 1'b1;
    start = st;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (s_ready) break;
    end
    if (k == 300) chk("send_timeout", 0, 1);
    else if (lat_chk != 0 && (idx % W) % 2 == 1 && (idx / W) % 2 == 1) acc_cyc.push_back(cyc);
    @(posedge clk); #1;
    s_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic frame(input int base, input bit gap, input int st_at);
    for (int i = 0; i < W * H; i++) begin
      send(base + i, i, i == st_at);
      if (i == st_at) chk("col_after_start", col, (i + 1) % W);
      if (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic begin_frame();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == 100) chk("done_timeout", 0, 1);
  endtask

  task automatic chk_res(input string tag, input int e0, input int e1, input int e2, input int e3);
    int e [4];
    e = '{e0, e1, e2, e3};
    chk({tag, "_count"}, got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk(tag, got[i], e[i]);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: no finish");
    $fatal(1);
  end

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_col", col, 0);
    chk("rst_row", row, 0);
    chk("rst_done", done, 0);

    got.delete(); done_cnt = 0; lat_chk = 1; shift_cnt = 0;
    begin_frame();
    chk("run_busy", busy, 1);
    frame(0, 1'b0, -1);
    wait_done();
    repeat (3) @(posedge clk); #1;
    lat_chk = 0;
    chk_res("basic", 6, 8, 16, 18);
    chk("basic_done_cnt", done_cnt, 1);
    chk("basic_lat_left", acc_cyc.size(), 0);
    chk("basic_shifts", shift_cnt, 25);
    chk("idle_busy", busy, 0);

    got.delete();
    begin_frame();
    frame(-100, 1'b0, -1);
    wait_done();
    @(posedge clk); #1;
`ifdef MAXPOOL_RELU_EN
    chk_res("neg", 0, 0, 0, 0);
`else
    chk_res("neg", -94, -92, -84, -82);
`endif

    got.delete(); m_ready = 1'b0;
    begin_frame();
    fork
      frame(0, 1'b0, -1);
    join_none
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (m_valid) break;
    end
    chk("bp_first", m_data, 6);
    repeat (5) @(negedge clk);
    chk("bp_hold_data", m_data, 6);
    chk("bp_hold_valid", m_valid, 1);
    chk("bp_s_ready", s_ready, 0);
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_done();
    @(posedge clk); #1;
    chk_res("bp", 6, 8, 16, 18);

    begin_frame();
    for (int i = 0; i < 12; i++) send(i, i, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_col", col, 0);
    chk("mid_rst_row", row, 0);
    got.delete();
    begin_frame();
    frame(0, 1'b0, -1);
    wait_done();
    @(posedge clk); #1;
    chk_res("after_rst", 6, 8, 16, 18);

    got.delete(); shift_cnt = 0;
    begin_frame();
    frame(0, 1'b1, 3);
    wait_done();
    @(posedge clk); #1;
    chk_res("gaps", 6, 8, 16, 18);
    chk("gaps_shifts", shift_cnt, 25);

    got.delete(); done_cnt = 0;
    begin_frame();
    frame(0, 1'b0, -1);
    wait_done();
    chk("b2b_busy_at_done", busy, 1);
    @(posedge clk); #1;
    chk("b2b_busy_after_done", busy, 0);
    begin_frame();
    frame(100, 1'b0, -1);
    wait_done();
    repeat (2) @(posedge clk); #1;
    chk("b2b_count", got.size(), 8);
    chk("b2b_done_cnt", done_cnt, 2);
    if (got.size() == 8) begin
      chk("b2b_r0", got[0], 6);
      chk("b2b_r3", got[3], 18);
      chk("b2b_r4", got[4], 106);
      chk("b2b_r7", got[7], 118);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
